// File: rtl/sobol_bsgen_pkg.sv
// Shared definitions for the Sobol unary bitstream generator: default RNG
// width and the controller state encoding.
package sobol_bsgen_pkg;

    localparam int DEF_BITWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sobol_bsgen_cnt.sv
// Stream-length counter: synchronous reset, clear on accept, advance on fire,
// and flag the final count of the stream.
module sobol_bsgen_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iClr,
    input  logic             iEn,
    output logic [WIDTH-1:0] oCnt,
    output logic             oTc
);

    // Counter register; wraps to zero naturally after the last step.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oCnt <= {WIDTH{1'b0}};
        end else if (iClr) begin
            oCnt <= {WIDTH{1'b0}};
        end else if (iEn) begin
            oCnt <= oCnt + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            oCnt <= oCnt;
        end
    end

    assign oTc = (oCnt == {WIDTH{1'b1}});

endmodule

// File: rtl/sobol_bsgen.sv
// Unary bitstream generator: compares each Sobol sample from the paired
// sobolrng against a latched source value and streams the result bits.
module sobol_bsgen
    import sobol_bsgen_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iSrcValid,
    output logic                oSrcReady,
    input  logic [BITWIDTH-1:0] iSrc,
    output logic                oRngEn,
    input  logic [BITWIDTH-1:0] iRng,
    output logic                oBit,
    output logic                oBitValid,
    input  logic                iBitReady,
    output logic                oLast,
    output logic                oDone,
    output logic [BITWIDTH:0]   oOneCnt
);

    state_t              state;
    logic [BITWIDTH-1:0] srcReg;
    logic [BITWIDTH-1:0] cnt;
    logic                cntTc;
    logic                accept;
    logic                fire;

    // The RNG only advances on fire, so a stalled bit keeps its sample.
    assign oBitValid = (state == RUN);
    assign oBit      = oBitValid && (iRng < srcReg);
    assign oRngEn    = oBitValid && iBitReady;
    assign fire      = oRngEn;
    assign oLast     = oBitValid && cntTc;
    assign accept    = (state == IDLE) && iSrcValid && oSrcReady;

    sobol_bsgen_cnt #(
        .WIDTH (BITWIDTH)
    ) uCnt (
        .iClk (iClk),
        .iRst (iRst),
        .iClr (accept),
        .iEn  (fire),
        .oCnt (cnt),
        .oTc  (cntTc)
    );

    // Controller FSM with registered handshake, done pulse and ones count.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state     <= IDLE;
            srcReg    <= {BITWIDTH{1'b0}};
            oOneCnt   <= {(BITWIDTH+1){1'b0}};
            oSrcReady <= 1'b1;
            oDone     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oDone <= 1'b0;
                    if (accept) begin
                        srcReg    <= iSrc;
                        oOneCnt   <= {(BITWIDTH+1){1'b0}};
                        oSrcReady <= 1'b0;
                        state     <= RUN;
                    end else begin
                        oSrcReady <= 1'b1;
                    end
                end
                RUN: begin
                    oSrcReady <= 1'b0;
                    if (fire) begin
                        oOneCnt <= oOneCnt + {{BITWIDTH{1'b0}}, oBit};
                        if (cntTc) begin
                            oDone <= 1'b1;
                            state <= DONE;
                        end else begin
                            oDone <= 1'b0;
                        end
                    end else begin
                        oDone <= 1'b0;
                    end
                end
                DONE: begin
                    // Ready returns only after the done pulse, never during it.
                    oDone     <= 1'b0;
                    oSrcReady <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    oDone     <= 1'b0;
                    oSrcReady <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_bsgen.sv
// Directed bench for sobol_bsgen at BITWIDTH=4, paired with a behavioural
// one-dimensional Sobol (van der Corput) sequence source.
module tb_sobol_bsgen;

    localparam int BW = 4;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iSrcValid;
    logic          oSrcReady;
    logic [BW-1:0] iSrc;
    logic          oRngEn;
    logic [BW-1:0] iRng;
    logic          oBit;
    logic          oBitValid;
    logic          iBitReady;
    logic          oLast;
    logic          oDone;
    logic [BW:0]   oOneCnt;

    int checks = 0;
    int errors = 0;

    // Sobol samples by index 0..15, written out by hand
    int sobolTab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    logic [BW-1:0] rngIdx;
    logic [15:0]   bitsA;
    logic [15:0]   bitsB;

    sobol_bsgen #(.BITWIDTH(BW)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iSrcValid (iSrcValid),
        .oSrcReady (oSrcReady),
        .iSrc      (iSrc),
        .oRngEn    (oRngEn),
        .iRng      (iRng),
        .oBit      (oBit),
        .oBitValid (oBitValid),
        .iBitReady (iBitReady),
        .oLast     (oLast),
        .oDone     (oDone),
        .oOneCnt   (oOneCnt)
    );

    always #5 iClk = ~iClk;

    // Paired RNG stand-in: registered index, bit-reversed output, shared reset
    always @(posedge iClk) begin
        if (iRst) rngIdx <= 4'd0;
        else if (oRngEn) rngIdx <= rngIdx + 4'd1;
    end
    assign iRng = {rngIdx[0], rngIdx[1], rngIdx[2], rngIdx[3]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic waitReady();
        int cyc = 0;
        while (oSrcReady !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("srcReady", 32'(oSrcReady), 32'd1);
    endtask

    task automatic runStream(input int src, input bit randReady, input bit holdValid,
                             output logic [15:0] bits);
        int k   = 0;
        int cyc = 0;
        bits = 16'd0;
        waitReady();
        iSrc      = 4'(src);
        iSrcValid = 1'b1;
        tick();
        if (holdValid) iSrc = 4'd7;
        else iSrcValid = 1'b0;
        check("firstValid", 32'(oBitValid), 32'd1);
        check("readyLowRun", 32'(oSrcReady), 32'd0);
        while (k < 16 && cyc < 400) begin
            iBitReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge iClk);
            if (!iBitReady) check("rngEnStall", 32'(oRngEn), 32'd0);
            if (oBitValid && iBitReady) begin
                check("bit", 32'(oBit), 32'(sobolTab[k] < src));
                check("last", 32'(oLast), 32'(k == 15));
                bits[k] = oBit;
                k++;
            end
            tick();
            cyc++;
        end
        iBitReady = 1'b1;
        iSrcValid = 1'b0;
        check("fires", 32'(k), 32'd16);
        check("done", 32'(oDone), 32'd1);
        check("validLowDone", 32'(oBitValid), 32'd0);
        check("readyLowDone", 32'(oSrcReady), 32'd0);
        check("oneCnt", 32'(oOneCnt), 32'(src));
        tick();
        check("donePulse", 32'(oDone), 32'd0);
        check("readyBack", 32'(oSrcReady), 32'd1);
        check("oneCntHeld", 32'(oOneCnt), 32'(src));
    endtask

    initial begin
        iRst      = 1'b1;
        iSrcValid = 1'b0;
        iSrc      = 4'd0;
        iBitReady = 1'b1;
        tick();
        tick();
        check("rstReady", 32'(oSrcReady), 32'd1);
        check("rstValid", 32'(oBitValid), 32'd0);
        check("rstBit", 32'(oBit), 32'd0);
        check("rstRngEn", 32'(oRngEn), 32'd0);
        check("rstLast", 32'(oLast), 32'd0);
        check("rstDone", 32'(oDone), 32'd0);
        check("rstOneCnt", 32'(oOneCnt), 32'd0);
        iRst = 1'b0;
        tick();

        runStream(5, 1'b0, 1'b0, bitsA);
        runStream(0, 1'b0, 1'b0, bitsA);
        check("zeroStream", 32'(bitsA), 32'd0);
        runStream(15, 1'b0, 1'b0, bitsA);

        // Stall independence: random backpressure must not change content
        runStream(9, 1'b0, 1'b0, bitsA);
        runStream(9, 1'b1, 1'b0, bitsB);
        check("stallSeq", 32'(bitsB), 32'(bitsA));

        // Back-to-back with valid held through RUN
        runStream(3, 1'b0, 1'b1, bitsA);
        runStream(12, 1'b0, 1'b0, bitsB);
        check("secondStartIdx0", 32'(bitsB[0]), 32'd1);

        // Mid-stream reset after 7 accepted bits
        waitReady();
        iSrc      = 4'd8;
        iSrcValid = 1'b1;
        tick();
        iSrcValid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("partialCnt", 32'(oOneCnt), 32'd4);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("midRstReady", 32'(oSrcReady), 32'd1);
        check("midRstValid", 32'(oBitValid), 32'd0);
        check("midRstBit", 32'(oBit), 32'd0);
        check("midRstLast", 32'(oLast), 32'd0);
        check("midRstDone", 32'(oDone), 32'd0);
        check("midRstOneCnt", 32'(oOneCnt), 32'd0);
        runStream(8, 1'b0, 1'b0, bitsA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
